// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests,
// drops stale responses after a redirect and buffers two instructions.
module fetch_unit #(
  parameter int unsigned AddressWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter logic [AddressWidth-1:0] ResetPc = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pc_src_sel_i,
  input  logic [AddressWidth-1:0] pc_target_i,
  output logic                    imem_req_o,
  output logic [AddressWidth-1:0] imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [DataWidth-1:0]    imem_rdata_i,
  output logic                    instr_valid_o,
  output logic [DataWidth-1:0]    instr_o,
  output logic [AddressWidth-1:0] instr_pc_o,
  input  logic                    instr_ready_i
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [AddressWidth-1:0] fetch_pc_q, fetch_pc_d;

  logic [1:0] infl_q, infl_d;
  logic [1:0][AddressWidth-1:0] ipc_q, ipc_d;

  logic [1:0] disc_q, disc_d;

  logic [1:0] oq_cnt_q, oq_cnt_d;
  logic [1:0][DataWidth-1:0] oq_instr_q, oq_instr_d;
  logic [1:0][AddressWidth-1:0] oq_pc_q, oq_pc_d;

  logic [2:0] credits;
  logic req;
  logic fire;
  logic rv;
  logic pop;
  logic wr;
  logic redirect;
  logic [1:0] infl_pop;
  logic [1:0] oq_pop;
  logic [AddressWidth-1:0] tgt_aligned;
  logic unused_tgt_bits;

  assign unused_tgt_bits = ^pc_target_i[1:0];

  assign credits = {1'b0, infl_q} + {1'b0, oq_cnt_q};
  assign req = (state_q == RUN) && (credits < 3'd2);
  assign fire = req && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv = imem_rvalid_i && (infl_q != 2'd0);
  assign pop = (oq_cnt_q != 2'd0) && instr_ready_i;
  assign redirect = pc_src_sel_i;
  assign wr = rv && (disc_q == 2'd0) && !redirect;

  assign infl_pop = infl_q - {1'b0, rv};
  assign oq_pop = oq_cnt_q - {1'b0, pop};
  assign tgt_aligned = {pc_target_i[AddressWidth-1:2], 2'b00};

  assign imem_req_o = req;
  assign imem_addr_o = fetch_pc_q;
  assign instr_valid_o = (oq_cnt_q != 2'd0);
  assign instr_o = oq_instr_q[0];
  assign instr_pc_o = oq_pc_q[0];

  // Next-state: queues, counters, PC and FSM; a redirect overrides all.
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    infl_d = infl_pop + {1'b0, fire};
    ipc_d = ipc_q;
    disc_d = disc_q;
    oq_cnt_d = oq_pop;
    oq_instr_d = oq_instr_q;
    oq_pc_d = oq_pc_q;

    if (rv) begin
      ipc_d[0] = ipc_q[1];
    end
    if (fire) begin
      if (infl_pop == 2'd0) begin
        ipc_d[0] = fetch_pc_q;
      end else begin
        ipc_d[1] = fetch_pc_q;
      end
      fetch_pc_d = fetch_pc_q + AddressWidth'(4);
    end

    if (pop) begin
      oq_instr_d[0] = oq_instr_q[1];
      oq_pc_d[0] = oq_pc_q[1];
    end
    if (wr) begin
      if (oq_pop == 2'd0) begin
        oq_instr_d[0] = imem_rdata_i;
        oq_pc_d[0] = ipc_q[0];
      end else begin
        oq_instr_d[1] = imem_rdata_i;
        oq_pc_d[1] = ipc_q[0];
      end
      oq_cnt_d = oq_pop + 2'd1;
    end

    if (rv && (disc_q != 2'd0)) begin
      disc_d = disc_q - 2'd1;
    end

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: state_d = RUN;
      DRAIN: begin
        if (disc_d == 2'd0) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (redirect) begin
      fetch_pc_d = tgt_aligned;
      oq_cnt_d = 2'd0;
      disc_d = infl_d;
      state_d = (infl_d == 2'd0) ? RUN : DRAIN;
    end
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      fetch_pc_q <= ResetPc;
      infl_q <= 2'd0;
      ipc_q <= '0;
      disc_q <= 2'd0;
      oq_cnt_q <= 2'd0;
      oq_instr_q <= '0;
      oq_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      infl_q <= infl_d;
      ipc_q <= ipc_d;
      disc_q <= disc_d;
      oq_cnt_q <= oq_cnt_d;
      oq_instr_q <= oq_instr_d;
      oq_pc_q <= oq_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table with a
// small in-order memory model, plus reset and protocol-error sequences.
module tb_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [31:0] DBASE = 32'hC0DE_0000;

  logic clk;
  logic rst_n;
  logic sel;
  logic [AW-1:0] tgt;
  logic req;
  logic [AW-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [DW-1:0] rdata;
  logic vld;
  logic [DW-1:0] instr;
  logic [AW-1:0] ipc;
  logic ready;

  fetch_unit #(
    .AddressWidth(AW),
    .DataWidth(DW),
    .ResetPc('0)
  ) u_dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .pc_src_sel_i(sel),
    .pc_target_i(tgt),
    .imem_req_o(req),
    .imem_addr_o(addr),
    .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .instr_valid_o(vld),
    .instr_o(instr),
    .instr_pc_o(ipc),
    .instr_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rdy;
    logic g;
    logic hold;
    logic s;
    logic [AW-1:0] t;
    logic ereq;
    logic [AW-1:0] eaddr;
    logic evld;
    logic [AW-1:0] epc;
  } vec_t;

  vec_t tab[$];
  logic [AW-1:0] pend[$];
  logic gnt_en;
  logic mem_hold;
  int n_chk;
  int n_fail;

  function automatic void add(logic r, logic g, logic h, logic s,
                              logic [AW-1:0] t, logic er,
                              logic [AW-1:0] ea, logic ev,
                              logic [AW-1:0] ep);
    vec_t v;
    v = '{r, g, h, s, t, er, ea, ev, ep};
    tab.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // In-order memory: answers one cycle after grant unless held.
  task automatic mem_step();
    logic r;
    logic [AW-1:0] a;
    r = !mem_hold && (pend.size() > 0);
    rvalid = r;
    rdata = '0;
    if (r) begin
      a = pend.pop_front();
      rdata = DBASE | {22'h0, a};
    end
    gnt = gnt_en;
    if (req && gnt_en) pend.push_back(addr);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    sel = 1'b0;
    tgt = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    ready = 1'b1;
    gnt_en = 1'b1;
    mem_hold = 1'b0;

    // rdy g hold sel tgt | req addr vld pc
    add(1, 1, 0, 0, 'h000, 1, 'h000, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h004, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h008, 1, 'h004);
    add(1, 1, 0, 0, 'h000, 1, 'h00C, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h008);
    add(1, 1, 0, 0, 'h000, 1, 'h010, 1, 'h00C);
    add(0, 1, 0, 0, 'h000, 1, 'h014, 0, 'h000);
    add(0, 1, 0, 0, 'h000, 0, 'h000, 1, 'h010);
    add(0, 1, 0, 0, 'h000, 0, 'h000, 1, 'h010);
    add(0, 1, 0, 0, 'h000, 0, 'h000, 1, 'h010);
    add(0, 1, 0, 0, 'h000, 0, 'h000, 1, 'h010);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h010);
    add(1, 1, 0, 0, 'h000, 1, 'h018, 1, 'h014);
    add(1, 1, 0, 0, 'h000, 1, 'h01C, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h018);
    add(1, 1, 0, 0, 'h000, 1, 'h020, 1, 'h01C);
    add(1, 1, 1, 0, 'h000, 1, 'h024, 0, 'h000);
    add(1, 1, 1, 1, 'h040, 0, 'h000, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h040, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h044, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h040);
    add(1, 0, 0, 1, 'h003, 1, 'h048, 1, 'h044);
    add(1, 1, 0, 0, 'h000, 1, 'h000, 0, 'h000);
    add(1, 1, 0, 1, 'h080, 1, 'h004, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h080, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h084, 0, 'h000);
    add(1, 0, 0, 1, 'h3F8, 0, 'h000, 1, 'h080);
    add(1, 1, 0, 0, 'h000, 1, 'h3F8, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 1, 'h3FC, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h3F8);
    add(1, 1, 0, 0, 'h000, 1, 'h000, 1, 'h3FC);
    add(1, 1, 0, 0, 'h000, 1, 'h004, 0, 'h000);
    add(1, 1, 0, 0, 'h000, 0, 'h000, 1, 'h000);

    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", {22'h0, addr}, 32'h0);
    chk("rst_vld", {31'h0, vld}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", {22'h0, ipc}, 32'h0);

    rst_n = 1'b1;
    chk("boot_req", {31'h0, req}, 32'h0);
    mem_step();
    tick();

    for (int i = 0; i < tab.size(); i++) begin
      chk($sformatf("row%0d req", i + 1), {31'h0, req},
          {31'h0, tab[i].ereq});
      if (tab[i].ereq)
        chk($sformatf("row%0d addr", i + 1), {22'h0, addr},
            {22'h0, tab[i].eaddr});
      chk($sformatf("row%0d vld", i + 1), {31'h0, vld},
          {31'h0, tab[i].evld});
      if (tab[i].evld) begin
        chk($sformatf("row%0d pc", i + 1), {22'h0, ipc},
            {22'h0, tab[i].epc});
        chk($sformatf("row%0d instr", i + 1), instr,
            DBASE | {22'h0, tab[i].epc});
      end
      ready = tab[i].rdy;
      gnt_en = tab[i].g;
      mem_hold = tab[i].hold;
      sel = tab[i].s;
      tgt = tab[i].t;
      mem_step();
      tick();
    end

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    sel = 1'b0;
    rvalid = 1'b0;
    gnt = 1'b0;
    pend.delete();
    #1;
    chk("mid_rst_req", {31'h0, req}, 32'h0);
    chk("mid_rst_addr", {22'h0, addr}, 32'h0);
    chk("mid_rst_vld", {31'h0, vld}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", {22'h0, ipc}, 32'h0);
    @(negedge clk);

    // Release with a spurious response while nothing is outstanding.
    rst_n = 1'b1;
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    gnt = 1'b1;
    tick();
    chk("err_vld", {31'h0, vld}, 32'h0);
    chk("err_req", {31'h0, req}, 32'h1);
    chk("err_addr", {22'h0, addr}, 32'h0);
    ready = 1'b1;
    gnt_en = 1'b1;
    mem_hold = 1'b0;
    mem_step();
    tick();
    chk("restart_req", {31'h0, req}, 32'h1);
    chk("restart_addr", {22'h0, addr}, 32'h4);
    chk("restart_vld", {31'h0, vld}, 32'h0);
    mem_step();
    tick();
    chk("restart_vld2", {31'h0, vld}, 32'h1);
    chk("restart_pc", {22'h0, ipc}, 32'h0);
    chk("restart_instr", instr, DBASE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
